// File: rtl/bpred_perceptron_train.sv
// Perceptron training stage: accepts a resolved-branch record, fetches its weight row,
// nudges each of the NW weights by t*x with saturation (one per cycle), then writes the row back.
module bpred_perceptron_train #(
  parameter int NW    = 8,
  parameter int WW    = 9,
  parameter int IDXW  = 8,
  parameter int ROWS  = 228,
  parameter int THETA = 27,
  parameter int WMAX  = 255
) (
  input  logic              fire,
  input  logic              rst,
  input  logic              i_resValid,
  output logic              o_resReady,
  input  logic              i_resTaken,
  input  logic              i_resPredTaken,
  input  logic [11:0]       i_resSum_12,
  input  logic [IDXW-1:0]   i_resIdx_8,
  input  logic [NW-2:0]     i_resHist_7,
  output logic [IDXW-1:0]   o_rdIdx_8,
  input  logic [NW*WW-1:0]  i_weightRow_72,
  output logic              o_wrValid,
  output logic [IDXW-1:0]   o_wrIdx_8,
  output logic [NW*WW-1:0]  o_wrRow_72,
  output logic              o_busy,
  output logic [15:0]       o_trainCount_16,
  output logic [7:0]        o_errCount_8
);

  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic signed [WW:0] W_HI  = (WW+1)'(WMAX);
  localparam logic signed [WW:0] W_LO  = -W_HI;
  localparam logic signed [WW:0] W_ONE = (WW+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, WRITE} state_t;

  state_t            state_reg, state_next;
  logic [KW-1:0]     k_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              taken_reg;
  logic [NW-2:0]     hist_reg;
  logic [NW*WW-1:0]  row_reg;
  logic [NW*WW-1:0]  row_upd;
  logic [IDXW-1:0]   rd_idx_reg;
  logic [IDXW-1:0]   wr_idx_reg;
  logic [NW*WW-1:0]  wr_row_reg;
  logic [15:0]       train_cnt_reg;
  logic [7:0]        err_cnt_reg;

  logic              accept;
  logic              idx_ok;
  logic              train;
  logic [12:0]       sum_ext;
  logic [12:0]       sum_abs;
  logic              k_last;

  // 13-bit magnitude so that -2048 maps to +2048 rather than wrapping
  assign sum_ext = {i_resSum_12[11], i_resSum_12};
  assign sum_abs = sum_ext[12] ? (~sum_ext + 13'd1) : sum_ext;
  assign accept  = i_resValid && (state_reg == IDLE);
  assign idx_ok  = 32'(i_resIdx_8) < ROWS;
  assign train   = (i_resTaken != i_resPredTaken) || (sum_abs <= 13'(THETA));
  assign k_last  = (k_reg == KW'(NW-1));

  // Serial weight datapath: x_vec bit 0 is the always-on bias input
  logic [NW-1:0]           x_vec;
  logic signed [WW-1:0]    w_arr [NW];
  logic signed [WW-1:0]    w_sel;
  logic signed [WW:0]      w_wide;
  logic signed [WW:0]      w_sum;
  logic signed [WW-1:0]    w_new;

  assign x_vec = {hist_reg, 1'b1};

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_w
      assign w_arr[gi] = row_reg[gi*WW +: WW];
      assign row_upd[gi*WW +: WW] = (k_reg == KW'(gi)) ? w_new : row_reg[gi*WW +: WW];
    end
  endgenerate

  assign w_sel = w_arr[k_reg];

  always_comb begin
    w_wide = {w_sel[WW-1], w_sel};
    if (taken_reg == x_vec[k_reg]) w_sum = w_wide + W_ONE;
    else                           w_sum = w_wide - W_ONE;
    if (w_sum > W_HI)      w_new = WW'(WMAX);
    else if (w_sum < W_LO) w_new = WW'(-WMAX);
    else                   w_new = w_sum[WW-1:0];
  end

  always_ff @(posedge fire or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_resReady = 1'b0;
    o_busy     = 1'b1;
    o_wrValid  = 1'b0;
    case (state_reg)
      IDLE: begin
        o_resReady = 1'b1;
        o_busy     = 1'b0;
        if (accept && train && idx_ok) state_next = FETCH;
      end
      FETCH:  state_next = UPDATE;
      UPDATE: if (k_last) state_next = WRITE;
      WRITE: begin
        o_wrValid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      k_reg         <= '0;
      idx_reg       <= '0;
      taken_reg     <= 1'b0;
      hist_reg      <= '0;
      row_reg       <= '0;
      rd_idx_reg    <= '0;
      wr_idx_reg    <= '0;
      wr_row_reg    <= '0;
      train_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            idx_reg   <= i_resIdx_8;
            taken_reg <= i_resTaken;
            hist_reg  <= i_resHist_7;
            if (!idx_ok) begin
              if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
            end else if (train) begin
              rd_idx_reg <= i_resIdx_8;
            end
          end
        end
        FETCH: begin
          row_reg <= i_weightRow_72;
          k_reg   <= '0;
        end
        UPDATE: begin
          row_reg <= row_upd;
          k_reg   <= k_reg + KW'(1);
          // Output registers load here so they are valid throughout the WRITE cycle
          if (k_last) begin
            wr_row_reg <= row_upd;
            wr_idx_reg <= idx_reg;
          end
        end
        WRITE: begin
          if (train_cnt_reg != 16'hFFFF) train_cnt_reg <= train_cnt_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_rdIdx_8       = rd_idx_reg;
  assign o_wrIdx_8       = wr_idx_reg;
  assign o_wrRow_72      = wr_row_reg;
  assign o_trainCount_16 = train_cnt_reg;
  assign o_errCount_8    = err_cnt_reg;

endmodule

// File: tb/tb_bpred_perceptron_train.sv
// Bench for bpred_perceptron_train: directed vector table, back-to-back and reset sequences,
// then randomized records checked against an integer reference model of the weight table.
module tb_bpred_perceptron_train;
  localparam int NW = 8, WW = 9, IDXW = 8, ROWS = 228, THETA = 27, WMAX = 255;
  localparam int RW = NW*WW;

  logic            fire = 1'b0;
  logic            rst;
  logic            i_resValid, o_resReady, i_resTaken, i_resPredTaken;
  logic [11:0]     i_resSum_12;
  logic [IDXW-1:0] i_resIdx_8, o_rdIdx_8, o_wrIdx_8;
  logic [NW-2:0]   i_resHist_7;
  logic [RW-1:0]   i_weightRow_72, o_wrRow_72;
  logic            o_wrValid, o_busy;
  logic [15:0]     o_trainCount_16;
  logic [7:0]      o_errCount_8;

  bpred_perceptron_train #(.NW(NW), .WW(WW), .IDXW(IDXW), .ROWS(ROWS), .THETA(THETA), .WMAX(WMAX)) dut (
    .fire(fire), .rst(rst),
    .i_resValid(i_resValid), .o_resReady(o_resReady),
    .i_resTaken(i_resTaken), .i_resPredTaken(i_resPredTaken),
    .i_resSum_12(i_resSum_12), .i_resIdx_8(i_resIdx_8), .i_resHist_7(i_resHist_7),
    .o_rdIdx_8(o_rdIdx_8), .i_weightRow_72(i_weightRow_72),
    .o_wrValid(o_wrValid), .o_wrIdx_8(o_wrIdx_8), .o_wrRow_72(o_wrRow_72),
    .o_busy(o_busy), .o_trainCount_16(o_trainCount_16), .o_errCount_8(o_errCount_8)
  );

  always #5 fire = ~fire;

  // Weight table environment: combinational read, committed from observed writes
  logic [RW-1:0] mem [256];
  assign i_weightRow_72 = mem[o_rdIdx_8];

  int total = 0, bad = 0, cyc = 0;
  int wr_seen = 0, wr_cyc = 0;
  logic [IDXW-1:0] wr_idx_seen;
  logic [RW-1:0]   wr_row_seen;
  bit model_on = 0;
  logic [IDXW-1:0] exp_idx_q [$];
  logic [RW-1:0]   exp_row_q [$];
  int exp_tc = 0, exp_ec = 0;
  int ref_w [256][NW];

  typedef struct {
    string         name;
    logic [7:0]    idx;
    bit            taken;
    bit            pred;
    int            sum;
    logic [6:0]    hist;
    logic [RW-1:0] init;
    bit            exp_wr;
    bit            exp_err;
    logic [RW-1:0] exp_row;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {WW'(a7), WW'(a6), WW'(a5), WW'(a4), WW'(a3), WW'(a2), WW'(a1), WW'(a0)};
  endfunction

  task automatic tick();
    @(posedge fire);
    #1;
    cyc++;
    if (o_wrValid === 1'b1) begin
      wr_seen++;
      wr_cyc      = cyc;
      wr_idx_seen = o_wrIdx_8;
      wr_row_seen = o_wrRow_72;
      mem[o_wrIdx_8] = o_wrRow_72;
      if (model_on) begin
        check("rand_write_expected", exp_idx_q.size() > 0, 1);
        if (exp_idx_q.size() > 0) begin
          check("rand_wr_idx", o_wrIdx_8, exp_idx_q.pop_front());
          check("rand_wr_row", o_wrRow_72, exp_row_q.pop_front());
        end
      end
    end
  endtask

  // Reference: each weight moves by t*x and is clamped to +/-WMAX
  task automatic model_train(input int idx, input bit taken, input logic [6:0] hist);
    int t, x, w;
    t = taken ? 1 : -1;
    for (int k = 0; k < NW; k++) begin
      if (k == 0)            x = 1;
      else if (hist[k-1])    x = 1;
      else                   x = -1;
      w = ref_w[idx][k] + t * x;
      if (w > WMAX)  w = WMAX;
      if (w < -WMAX) w = -WMAX;
      ref_w[idx][k] = w;
    end
  endtask

  function automatic logic [RW-1:0] pack_ref(input int idx);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r[k*WW +: WW] = WW'(ref_w[idx][k]);
    return r;
  endfunction

  function automatic bit model_decide(input bit taken, input bit pred, input int sum);
    int mag;
    mag = (sum < 0) ? -sum : sum;
    return (taken != pred) || (mag <= THETA);
  endfunction

  task automatic run_vec(input vec_t v);
    int w0, acc;
    mem[v.idx] = v.init;
    w0 = wr_seen;
    check({v.name, "_ready_before"}, o_resReady, 1);
    i_resIdx_8 = v.idx; i_resTaken = v.taken; i_resPredTaken = v.pred;
    i_resSum_12 = 12'(v.sum); i_resHist_7 = v.hist; i_resValid = 1'b1;
    tick();
    acc = cyc;
    i_resValid = 1'b0;
    check({v.name, "_busy_c1"}, o_busy, v.exp_wr);
    if (v.exp_wr) check({v.name, "_rd_idx"}, o_rdIdx_8, v.idx);
    repeat (12) tick();
    exp_tc += int'(v.exp_wr);
    exp_ec += int'(v.exp_err);
    check({v.name, "_nwrites"}, wr_seen - w0, int'(v.exp_wr));
    if (v.exp_wr) begin
      check({v.name, "_wr_idx"}, wr_idx_seen, v.idx);
      check({v.name, "_wr_row"}, wr_row_seen, v.exp_row);
      check({v.name, "_wr_latency"}, wr_cyc - acc, 9);
    end
    check({v.name, "_train_count"}, o_trainCount_16, exp_tc);
    check({v.name, "_err_count"}, o_errCount_8, exp_ec);
    check({v.name, "_ready_after"}, o_resReady, 1);
  endtask

  int first_ready, acc2, w0, accepted, r, s;
  logic [7:0] r_idx;
  bit r_taken, r_pred;
  logic [6:0] r_hist;

  initial begin
    rst = 1'b1;
    i_resValid = 1'b0; i_resTaken = 1'b0; i_resPredTaken = 1'b0;
    i_resSum_12 = '0; i_resIdx_8 = '0; i_resHist_7 = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs[0]  = '{"mispredict",   8'd5,   1, 0, -40,   7'b1010101, '0, 1, 0, mkrow(1, 1, -1, 1, -1, 1, -1, 1)};
    vecs[1]  = '{"confident",    8'd7,   1, 1, 100,   7'h00, '0, 0, 0, '0};
    vecs[2]  = '{"saturate",     8'd10,  0, 0, -27,   7'h00, mkrow(-255, 255, 255, 255, 255, 255, 255, 255), 1, 0,
                 mkrow(-255, 255, 255, 255, 255, 255, 255, 255)};
    vecs[3]  = '{"idx228",       8'd228, 1, 0, 0,     7'h00, '0, 0, 1, '0};
    vecs[4]  = '{"sum_m2048",    8'd4,   0, 0, -2048, 7'h00, '0, 0, 0, '0};
    vecs[5]  = '{"sum_p27",      8'd3,   1, 1, 27,    7'h7F, '0, 1, 0, mkrow(1, 1, 1, 1, 1, 1, 1, 1)};
    vecs[6]  = '{"sum_p28",      8'd6,   1, 1, 28,    7'h7F, '0, 0, 0, '0};
    vecs[7]  = '{"idx227",       8'd227, 0, 1, 500,   7'h00, '0, 1, 0, mkrow(-1, 1, 1, 1, 1, 1, 1, 1)};
    vecs[8]  = '{"idx255",       8'd255, 0, 1, 0,     7'h00, '0, 0, 1, '0};
    vecs[9]  = '{"cap_m256",     8'd20,  1, 0, 0,     7'h00, mkrow(-256, 0, 0, 0, 0, 0, 0, 0), 1, 0,
                 mkrow(-255, -1, -1, -1, -1, -1, -1, -1)};
    vecs[10] = '{"sum_m28",      8'd21,  0, 0, -28,   7'h00, '0, 0, 0, '0};

    repeat (3) @(posedge fire);
    #1;
    check("rst_ready", o_resReady, 1);
    check("rst_busy", o_busy, 0);
    check("rst_wrvalid", o_wrValid, 0);
    check("rst_wridx", o_wrIdx_8, 0);
    check("rst_wrrow", o_wrRow_72, 0);
    check("rst_rdidx", o_rdIdx_8, 0);
    check("rst_counts", {o_trainCount_16, o_errCount_8}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Back-to-back to idx 9: second record held valid while the first trains
    mem[9] = '0;
    w0 = wr_seen;
    i_resIdx_8 = 8'd9; i_resTaken = 1'b1; i_resPredTaken = 1'b0; i_resSum_12 = '0; i_resHist_7 = '0;
    i_resValid = 1'b1;
    tick();
    first_ready = -1;
    for (int c = 1; c <= 20; c++) begin
      if (o_resReady) begin
        first_ready = c;
        break;
      end
      tick();
    end
    check("b2b_first_ready_cycle", first_ready, 11);
    tick();
    acc2 = cyc;
    i_resValid = 1'b0;
    repeat (12) tick();
    exp_tc += 2;
    check("b2b_nwrites", wr_seen - w0, 2);
    check("b2b_wr_idx", wr_idx_seen, 9);
    check("b2b_wr_row", wr_row_seen, mkrow(2, -2, -2, -2, -2, -2, -2, -2));
    check("b2b_latency", wr_cyc - acc2, 9);
    check("b2b_train_count", o_trainCount_16, exp_tc);

    // Randomized records against the reference model
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < NW; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      ref_w[i][k] = -256;
        else if (r == 1) ref_w[i][k] = 255;
        else if (r == 2) ref_w[i][k] = -255;
        else             ref_w[i][k] = int'($urandom_range(0, 510)) - 255;
      end
      mem[i] = pack_ref(i);
    end
    model_on = 1;
    accepted = 0;
    while (accepted < 80 && cyc < 5000) begin
      if (o_resReady) begin
        if ($urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 15);
          r_idx   = (r < 12) ? 8'(224 + (r % 6)) : 8'($urandom_range(0, 255));
          r_taken = 1'($urandom_range(0, 1));
          r_pred  = 1'($urandom_range(0, 1));
          r_hist  = 7'($urandom);
          r = $urandom_range(0, 7);
          if (r == 0)      s = -2048;
          else if (r == 1) s = int'($urandom_range(0, 4095)) - 2048;
          else             s = int'($urandom_range(0, 60)) - 30;
          i_resIdx_8 = r_idx; i_resTaken = r_taken; i_resPredTaken = r_pred;
          i_resSum_12 = 12'(s); i_resHist_7 = r_hist; i_resValid = 1'b1;
          accepted++;
          if (int'(r_idx) >= ROWS) begin
            if (exp_ec < 255) exp_ec++;
          end else if (model_decide(r_taken, r_pred, s)) begin
            model_train(int'(r_idx), r_taken, r_hist);
            exp_idx_q.push_back(r_idx);
            exp_row_q.push_back(pack_ref(int'(r_idx)));
            if (exp_tc < 65535) exp_tc++;
          end
        end else begin
          i_resValid = 1'b0;
        end
      end else begin
        // Ignored while busy: arbitrary junk on the record inputs
        i_resValid = 1'($urandom_range(0, 1));
        i_resIdx_8 = 8'($urandom); i_resTaken = 1'($urandom); i_resPredTaken = 1'($urandom);
        i_resSum_12 = 12'($urandom); i_resHist_7 = 7'($urandom);
      end
      tick();
    end
    i_resValid = 1'b0;
    repeat (14) tick();
    check("rand_accepted", accepted, 80);
    check("rand_pending_writes", exp_idx_q.size(), 0);
    check("rand_train_count", o_trainCount_16, exp_tc);
    check("rand_err_count", o_errCount_8, exp_ec);
    model_on = 0;

    // Reset while in UPDATE at k=3 (cycle 5 after acceptance)
    i_resIdx_8 = 8'd1; i_resTaken = 1'b1; i_resPredTaken = 1'b0; i_resSum_12 = '0; i_resHist_7 = '0;
    i_resValid = 1'b1;
    tick();
    i_resValid = 1'b0;
    repeat (4) tick();
    check("mid_busy_before_rst", o_busy, 1);
    w0 = wr_seen;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", o_resReady, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_wrvalid", o_wrValid, 0);
    check("mid_rst_train_count", o_trainCount_16, 0);
    check("mid_rst_err_count", o_errCount_8, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    check("mid_rst_no_write", wr_seen - w0, 0);
    check("mid_rst_ready_after", o_resReady, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
